// File: rtl/pe_result_drain_if.sv
// Result stream from pe_result_drain toward the output buffer: one word per
// valid/ready handshake, tagged with its lane index and a last flag.
interface pe_result_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PE     = 4
);
  localparam int IDX_W = $clog2(NUM_PE);

  logic [DATA_WIDTH-1:0] out_data_O;
  logic [IDX_W-1:0]      out_idx_O;
  logic                  out_valid_O;
  logic                  out_ready_I;
  logic                  out_last_O;

  modport master (
    output out_data_O,
    output out_idx_O,
    output out_valid_O,
    output out_last_O,
    input  out_ready_I
  );

  modport slave (
    input  out_data_O,
    input  out_idx_O,
    input  out_valid_O,
    input  out_last_O,
    output out_ready_I
  );
endinterface

// File: rtl/pe_result_drain.sv
// Pass sequencer and result drain for one column of MAC PEs: clear, accumulate
// for k_len cycles, settle, snapshot, stream. PE_DRAIN_OVERLAP_EN overlaps drain with the next pass.
module pe_result_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PE     = 4,
  parameter int K_WIDTH    = 16,
  parameter int FMA_LAT    = 2
) (
  input  logic                         clk_I,
  input  logic                         rst_n_I,
  input  logic                         start_I,
  input  logic [K_WIDTH-1:0]           k_len_I,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_result_I,
  output logic                         pe_clear_O,
  output logic                         acc_en_O,
  output logic                         busy_O,
  output logic                         done_O,
  pe_result_drain_if.master            out_if
);

  localparam int IDX_W = $clog2(NUM_PE);
  localparam int SET_W = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;

  localparam logic [SET_W-1:0]   SET_INIT = SET_W'(FMA_LAT - 1);
  localparam logic [SET_W-1:0]   SET_ONE  = SET_W'(1);
  localparam logic [K_WIDTH-1:0] K_ONE    = K_WIDTH'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_PE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SETTLE,
    S_DRAIN
  } state_e;

  logic [K_WIDTH-1:0]    cnt_q, cnt_d;
  logic [SET_W-1:0]      set_q, set_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pe_clear_q, pe_clear_d;
  logic                  acc_en_q, acc_en_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;
  logic                  capture;
  logic                  hs;
  logic                  hs_last;

  logic [DATA_WIDTH-1:0] lane_in  [NUM_PE];
  logic [DATA_WIDTH-1:0] shadow_q [NUM_PE];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_PE];

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
    assign lane_in[gi]  = pe_result_I[gi*DATA_WIDTH +: DATA_WIDTH];
    assign shadow_d[gi] = capture ? lane_in[gi] : shadow_q[gi];
  end

  assign hs      = out_valid_q && out_if.out_ready_I;
  assign hs_last = hs && (idx_q == IDX_LAST);

`ifdef PE_DRAIN_OVERLAP_EN
  // Accumulate side walks IDLE/CLEAR/ACCUM/SETTLE; drain side walks IDLE/DRAIN.
  state_e acc_state_q, acc_state_d;
  state_e drn_state_q, drn_state_d;

  always_comb begin
    acc_state_d = acc_state_q;
    drn_state_d = drn_state_q;
    cnt_d       = cnt_q;
    set_d       = set_q;
    capture     = 1'b0;

    if ((drn_state_q == S_DRAIN) && hs_last) begin
      drn_state_d = S_IDLE;
    end

    case (acc_state_q)
      S_IDLE: begin
        if (start_I) begin
          acc_state_d = S_CLEAR;
          cnt_d       = k_len_I;
        end
      end
      S_CLEAR: begin
        if (cnt_q != '0) begin
          acc_state_d = S_ACCUM;
        end else begin
          acc_state_d = S_SETTLE;
          set_d       = SET_INIT;
        end
      end
      S_ACCUM: begin
        if (cnt_q == K_ONE) begin
          acc_state_d = S_SETTLE;
          set_d       = SET_INIT;
        end
        cnt_d = cnt_q - K_ONE;
      end
      S_SETTLE: begin
        if (set_q != '0) begin
          set_d = set_q - SET_ONE;
        end else if ((drn_state_q == S_IDLE) || hs_last) begin
          // Shadow is free (or frees this cycle): snapshot and restart drain at lane 0.
          capture     = 1'b1;
          acc_state_d = S_IDLE;
          drn_state_d = S_DRAIN;
        end
      end
      default: acc_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      acc_state_q <= S_IDLE;
      drn_state_q <= S_IDLE;
    end else begin
      acc_state_q <= acc_state_d;
      drn_state_q <= drn_state_d;
    end
  end

  assign pe_clear_d  = (acc_state_d == S_CLEAR);
  assign acc_en_d    = (acc_state_d == S_ACCUM);
  assign out_valid_d = (drn_state_d == S_DRAIN);
  assign busy_O      = (acc_state_q != S_IDLE) || (drn_state_q != S_IDLE);
`else
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_I) begin
          state_d = S_CLEAR;
          cnt_d   = k_len_I;
        end
      end
      S_CLEAR: begin
        if (cnt_q != '0) begin
          state_d = S_ACCUM;
        end else begin
          state_d = S_SETTLE;
          set_d   = SET_INIT;
        end
      end
      S_ACCUM: begin
        if (cnt_q == K_ONE) begin
          state_d = S_SETTLE;
          set_d   = SET_INIT;
        end
        cnt_d = cnt_q - K_ONE;
      end
      S_SETTLE: begin
        if (set_q != '0) begin
          set_d = set_q - SET_ONE;
        end else begin
          capture = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pe_clear_d  = (state_d == S_CLEAR);
  assign acc_en_d    = (state_d == S_ACCUM);
  assign out_valid_d = (state_d == S_DRAIN);
  assign busy_O      = (state_q != S_IDLE);
`endif

  always_comb begin
    idx_d  = idx_q;
    done_d = hs_last;
    if (hs) begin
      idx_d = hs_last ? '0 : (idx_q + IDX_ONE);
    end
  end

  // Control outputs come straight from flops so pe_clear_O is glitch-free into the PE reset.
  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      cnt_q       <= '0;
      set_q       <= '0;
      idx_q       <= '0;
      pe_clear_q  <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      set_q       <= set_d;
      idx_q       <= idx_d;
      pe_clear_q  <= pe_clear_d;
      acc_en_q    <= acc_en_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      for (int i = 0; i < NUM_PE; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign pe_clear_O         = pe_clear_q;
  assign acc_en_O           = acc_en_q;
  assign done_O             = done_q;
  assign out_if.out_valid_O = out_valid_q;
  assign out_if.out_idx_O   = idx_q;
  assign out_if.out_data_O  = out_valid_q ? shadow_q[idx_q] : '0;
  assign out_if.out_last_O  = out_valid_q && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_pe_result_drain.sv
// Scoreboard bench for pe_result_drain: directed passes push expected words,
// a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_pe_result_drain;
  localparam int DW  = 32;
  localparam int NPE = 4;
  localparam int KW  = 16;
  localparam int FL  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic [NPE*DW-1:0] pe_result;
  logic              pe_clear, acc_en, busy, done;

  pe_result_drain_if #(.DATA_WIDTH(DW), .NUM_PE(NPE)) out_if ();

  pe_result_drain #(
    .DATA_WIDTH(DW),
    .NUM_PE    (NPE),
    .K_WIDTH   (KW),
    .FMA_LAT   (FL)
  ) dut (
    .clk_I      (clk),
    .rst_n_I    (rst_n),
    .start_I    (start),
    .k_len_I    (k_len),
    .pe_result_I(pe_result),
    .pe_clear_O (pe_clear),
    .acc_en_O   (acc_en),
    .busy_O     (busy),
    .done_O     (done),
    .out_if     (out_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // PE column model: cleared by pe_clear, partial sums while fed, final value FMA_LAT after last operand
  logic [31:0] target [NPE];
  logic [31:0] lane   [NPE];
  int          m_acc = 0;

  always @(posedge clk) begin
    if (pe_clear) begin
      for (int i = 0; i < NPE; i++) lane[i] <= 32'h0;
      m_acc <= 0;
    end else if (acc_en) begin
      for (int i = 0; i < NPE; i++) lane[i] <= 32'hBAD0_0000 + 32'(i * 256) + 32'(m_acc);
      m_acc <= m_acc + 1;
    end else if (m_acc != 0) begin
      for (int i = 0; i < NPE; i++) lane[i] <= target[i];
      m_acc <= 0;
    end
  end

  always_comb begin
    for (int i = 0; i < NPE; i++) pe_result[i*DW +: DW] = lane[i];
  end

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_pass(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    exp_t e;
    logic [31:0] w [NPE];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < NPE; i++) begin
      e.data = w[i];
      e.idx  = 2'(i);
      e.last = (i == NPE - 1);
      exp_q.push_back(e);
    end
  endtask

  // Per-pass event records, filled by the monitor
  int done_cnt  = 0;
  int hs_cnt    = 0;
  int clr_cnt   = 0;
  int clr_first = -1;
  int acc_cnt   = 0;
  int acc_first = -1;
  int acc_last  = -1;
  int vld_first = -1;

  task automatic clear_rec();
    hs_cnt = 0; clr_cnt = 0; clr_first = -1;
    acc_cnt = 0; acc_first = -1; acc_last = -1; vld_first = -1;
  endtask

  logic        exp_done_nxt = 1'b0;
  logic        stall_prev   = 1'b0;
  logic [31:0] prev_data    = '0;
  logic [1:0]  prev_idx     = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done || exp_done_nxt) check("done_pulse", 32'(done), 32'(exp_done_nxt));
      exp_done_nxt = 1'b0;
      if (done) done_cnt++;
      if (pe_clear) begin
        clr_cnt++;
        if (clr_first < 0) clr_first = cyc;
      end
      if (acc_en) begin
        acc_cnt++;
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
      end
      if (out_if.out_valid_O && vld_first < 0) vld_first = cyc;
      if (stall_prev) begin
        check("stall_valid", 32'(out_if.out_valid_O), 32'd1);
        check("stall_data", out_if.out_data_O, prev_data);
        check("stall_idx", 32'(out_if.out_idx_O), 32'(prev_idx));
      end
      if (out_if.out_valid_O && out_if.out_ready_I) begin
        hs_cnt++;
        $display("xfer cyc=%0d idx=%0d data=0x%08h last=%0b",
                 cyc, out_if.out_idx_O, out_if.out_data_O, out_if.out_last_O);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_word: got idx %0d data 0x%08h, expected no word",
                   out_if.out_idx_O, out_if.out_data_O);
        end else begin
          e = exp_q.pop_front();
          check("word_data", out_if.out_data_O, e.data);
          check("word_idx", 32'(out_if.out_idx_O), 32'(e.idx));
          check("word_last", 32'(out_if.out_last_O), 32'(e.last));
          exp_done_nxt = e.last;
        end
      end
      stall_prev = out_if.out_valid_O && !out_if.out_ready_I;
      prev_data  = out_if.out_data_O;
      prev_idx   = out_if.out_idx_O;
    end else begin
      stall_prev   = 1'b0;
      exp_done_nxt = 1'b0;
    end
  end

  int t0 = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [KW-1:0] k);
    step();
    start = 1'b1;
    k_len = k;
    t0    = cyc;
    clear_rec();
    step();
    start = 1'b0;
    k_len = '0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt <= base && n < budget) begin
      step();
      n++;
    end
    check("done_seen", 32'(done_cnt > base), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!out_if.out_valid_O && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(out_if.out_valid_O), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pe_clear"}, 32'(pe_clear), 32'd0);
    check({tag, "_acc_en"}, 32'(acc_en), 32'd0);
    check({tag, "_valid"}, 32'(out_if.out_valid_O), 32'd0);
    check({tag, "_data"}, out_if.out_data_O, 32'd0);
    check({tag, "_idx"}, 32'(out_if.out_idx_O), 32'd0);
    check({tag, "_last"}, 32'(out_if.out_last_O), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int   base;

  initial begin
    out_if.out_ready_I = 1'b1;
    for (int i = 0; i < NPE; i++) target[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    while (cyc < 9) step();

    // Pass 1: k=3, lanes 1.0..4.0, ready always high, start at T=10
    target[0] = 32'h3F80_0000; target[1] = 32'h4000_0000;
    target[2] = 32'h4040_0000; target[3] = 32'h4080_0000;
    push_pass(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    base = done_cnt;
    start_pass(16'd3);
    wait_done(base, 40);
    check("p1_t0", 32'(t0), 32'd10);
    check("p1_clear_cyc", 32'(clr_first), 32'(t0 + 1));
    check("p1_clear_cnt", 32'(clr_cnt), 32'd1);
    check("p1_acc_cnt", 32'(acc_cnt), 32'd3);
    check("p1_acc_first", 32'(acc_first), 32'(t0 + 2));
    check("p1_acc_last", 32'(acc_last), 32'(t0 + 4));
    check("p1_valid_first", 32'(vld_first), 32'(t0 + 7));
    check("p1_words_left", 32'(exp_q.size()), 32'd0);
    step();
    check("p1_busy_after", 32'(busy), 32'd0);

    // Pass 2: same pass, ready toggling 1,0,0,1,0,1,1 from the first valid cycle
    out_if.out_ready_I = 1'b0;
    push_pass(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    base = done_cnt;
    start_pass(16'd3);
    wait_valid("p2_valid_seen", 40);
    for (int i = 0; i < 7; i++) begin
      out_if.out_ready_I = pat[i];
      step();
    end
    out_if.out_ready_I = 1'b1;
    wait_done(base, 20);
    check("p2_xfers", 32'(hs_cnt), 32'd4);
    check("p2_words_left", 32'(exp_q.size()), 32'd0);

    // Pass 3: k=0 drains four zero words, no operand feed
    for (int i = 0; i < NPE; i++) target[i] = 32'h0;
    push_pass(32'h0, 32'h0, 32'h0, 32'h0);
    base = done_cnt;
    start_pass(16'd0);
    wait_done(base, 40);
    check("p3_acc_cnt", 32'(acc_cnt), 32'd0);
    check("p3_clear_cyc", 32'(clr_first), 32'(t0 + 1));
    check("p3_valid_first", 32'(vld_first), 32'(t0 + 4));
    check("p3_words_left", 32'(exp_q.size()), 32'd0);

`ifndef PE_DRAIN_OVERLAP_EN
    // Pass 4: start pulsed in ACCUM and in the last-handshake cycle, both ignored
    target[0] = 32'h4100_0000; target[1] = 32'h4110_0000;
    target[2] = 32'h4120_0000; target[3] = 32'h4130_0000;
    push_pass(32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000);
    out_if.out_ready_I = 1'b0;
    base = done_cnt;
    start_pass(16'd3);
    for (int n = 0; n < 10 && !acc_en; n++) step();
    check("p4_in_accum", 32'(acc_en), 32'd1);
    start = 1'b1;
    k_len = 16'd5;
    step();
    start = 1'b0;
    k_len = '0;
    wait_valid("p4_valid_seen", 40);
    repeat (3) begin
      out_if.out_ready_I = 1'b1;
      step();
    end
    check("p4_idx_at_last", 32'(out_if.out_idx_O), 32'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    check("p4_done_pulses", 32'(done_cnt - base), 32'd1);
    check("p4_clear_cnt", 32'(clr_cnt), 32'd1);
    check("p4_acc_cnt", 32'(acc_cnt), 32'd3);
    check("p4_xfers", 32'(hs_cnt), 32'd4);
    check("p4_busy_after", 32'(busy), 32'd0);
    check("p4_words_left", 32'(exp_q.size()), 32'd0);
`endif

    // Pass 5: reset during DRAIN after lane 1, then a clean pass
    target[0] = 32'h3FC0_0000; target[1] = 32'h4020_0000;
    target[2] = 32'h4060_0000; target[3] = 32'h4090_0000;
    push_pass(32'h3FC0_0000, 32'h4020_0000, 32'h4060_0000, 32'h4090_0000);
    out_if.out_ready_I = 1'b0;
    base = done_cnt;
    start_pass(16'd2);
    wait_valid("p5_valid_seen", 40);
    repeat (2) begin
      out_if.out_ready_I = 1'b1;
      step();
    end
    out_if.out_ready_I = 1'b0;
    check("p5_idx_before_rst", 32'(out_if.out_idx_O), 32'd2);
    check("p5_data_before_rst", out_if.out_data_O, 32'h4060_0000);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    step();
    rst_n = 1'b1;
    out_if.out_ready_I = 1'b1;
    clear_rec();
    repeat (10) step();
    check("p5_xfers_after_rst", 32'(hs_cnt), 32'd0);
    check("p5_valid_after_rst", 32'(vld_first), 32'hFFFF_FFFF);
    check("p5_no_done", 32'(done_cnt - base), 32'd0);

    target[0] = 32'hC000_0000; target[1] = 32'h3F00_0000;
    target[2] = 32'h42C8_0000; target[3] = 32'hBF80_0000;
    push_pass(32'hC000_0000, 32'h3F00_0000, 32'h42C8_0000, 32'hBF80_0000);
    base = done_cnt;
    start_pass(16'd1);
    wait_done(base, 40);
    check("p6_acc_cnt", 32'(acc_cnt), 32'd1);
    check("p6_valid_first", 32'(vld_first), 32'(t0 + 5));
    check("p6_words_left", 32'(exp_q.size()), 32'd0);

`ifdef PE_DRAIN_OVERLAP_EN
    // Overlap: second pass starts while the first is stalled in DRAIN
    target[0] = 32'h4040_0000; target[1] = 32'h40A0_0000;
    target[2] = 32'h40E0_0000; target[3] = 32'h4110_0000;
    push_pass(32'h4040_0000, 32'h40A0_0000, 32'h40E0_0000, 32'h4110_0000);
    out_if.out_ready_I = 1'b0;
    base = done_cnt;
    start_pass(16'd1);
    wait_valid("ov_valid_seen", 40);
    target[0] = 32'h4130_0000; target[1] = 32'h4150_0000;
    target[2] = 32'h4170_0000; target[3] = 32'h4188_0000;
    push_pass(32'h4130_0000, 32'h4150_0000, 32'h4170_0000, 32'h4188_0000);
    start_pass(16'd1);
    repeat (12) step();
    check("ov_busy_stalled", 32'(busy), 32'd1);
    check("ov_idx_stalled", 32'(out_if.out_idx_O), 32'd0);
    check("ov_data_stalled", out_if.out_data_O, 32'h4040_0000);
    check("ov_second_clear", 32'(clr_cnt), 32'd1);
    out_if.out_ready_I = 1'b1;
    for (int n = 0; n < 60 && (done_cnt - base) < 2; n++) step();
    check("ov_done_pulses", 32'(done_cnt - base), 32'd2);
    check("ov_xfers", 32'(hs_cnt), 32'd8);
    check("ov_words_left", 32'(exp_q.size()), 32'd0);
    step();
    check("ov_busy_after", 32'(busy), 32'd0);
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
